// File: rtl/fetch_ras_unit_pkg.sv
// y86_pkg: Y86-64 icode and status encodings plus per-instruction length and register-byte
// helpers, shared by the fetch stage and its return-address stack.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Encoded length in bytes; invalid icodes advance by one byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
      I_JXX, I_CALL:                    len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
      default:                          len = 4'd1;
    endcase
    return len;
  endfunction

  // True when byte 1 carries the rA:rB register specifier.
  function automatic logic has_regs(input logic [3:0] icode);
    logic r;
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:            r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_ras_unit_if.sv
// Instruction-memory port of the fetch stage: address out, 10-byte window and error back.
interface fetch_ras_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] imem_addr;
  logic [79:0]       imem_bytes;
  logic              imem_error;

  modport master (output imem_addr, input imem_bytes, input imem_error);
  modport slave  (input imem_addr, output imem_bytes, output imem_error);
endinterface

// File: rtl/fetch_ras_unit_ras.sv
// fetch_ras: circular return-address stack. Pushing when full overwrites the oldest entry;
// popping when empty leaves it empty. Only used when FETCH_RAS_EN is defined.
module fetch_ras #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   ptr_q;  // next free slot; top lives at ptr_q - 1
  logic [CntW-1:0]   cnt_q;
  logic [PtrW-1:0]   top_idx;

  assign top_idx = ptr_q - PtrW'(1);
  assign top     = mem[top_idx];
  assign empty   = (cnt_q == '0);

  // Pointer and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrW'(1);
      if (cnt_q != CntW'(DEPTH)) cnt_q <= cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_ras_unit.sv
// fetch_ras_unit: Y86-64 fetch stage. Holds F_predPC, selects the fetch PC, splits the
// instruction window into fields and predicts the next PC. Define FETCH_RAS_EN to add a
// return-address stack that predicts ret targets.
module fetch_ras_unit
  import y86_pkg::*;
#(
  parameter int unsigned    ADDR_W    = 64,
  parameter int unsigned    RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [63:0]       M_valA,
  input  logic [3:0]        W_icode,
  input  logic [63:0]       W_valM,
  input  logic              ret_mispredict,
  fetch_ras_unit_if.master  imem,
  output logic [ADDR_W-1:0] f_PC,
  output logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] f_predPC,
  output logic [3:0]        f_icode,
  output logic [3:0]        f_ifun,
  output logic [3:0]        f_rA,
  output logic [3:0]        f_rB,
  output logic [63:0]       f_valC,
  output logic [2:0]        f_stat
);

  logic [ADDR_W-1:0] F_predPC;
  logic              w_redirect;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_push;
  logic              ras_pop;

`ifdef FETCH_RAS_EN
  assign w_redirect = (W_icode == I_RET) && ret_mispredict;
`else
  logic unused_ret_mispredict;
  assign unused_ret_mispredict = ret_mispredict;
  assign w_redirect = (W_icode == I_RET);
`endif

  // F pipeline register: predicted PC for the next fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) F_predPC <= RESET_PC;
    else if (!F_stall) F_predPC <= f_predPC;
  end

  // PC select: W ret redirect beats M mispredicted jump, which beats prediction.
  always_comb begin
    f_PC = F_predPC;
    if (w_redirect) f_PC = W_valM[ADDR_W-1:0];
    else if (M_icode == I_JXX && !M_cnd) f_PC = M_valA[ADDR_W-1:0];
  end

  assign imem.imem_addr = f_PC;

  // Field split, status, length and sequential PC.
  always_comb begin
    f_icode = imem.imem_bytes[7:4];
    f_ifun  = imem.imem_bytes[3:0];
    if (imem.imem_error) begin
      f_icode = I_NOP;
      f_ifun  = 4'h0;
    end

    if (imem.imem_error)       f_stat = STAT_ADR;
    else if (f_icode > I_POPQ) f_stat = STAT_INS;
    else if (f_icode == I_HALT) f_stat = STAT_HLT;
    else                       f_stat = STAT_AOK;

    f_rA = R_NONE;
    f_rB = R_NONE;
    if (has_regs(f_icode)) begin
      f_rA = imem.imem_bytes[15:12];
      f_rB = imem.imem_bytes[11:8];
    end

    f_valC = 64'h0;
    if (f_icode == I_JXX || f_icode == I_CALL) f_valC = imem.imem_bytes[71:8];
    else if (f_icode == I_IRMOVQ || f_icode == I_RMMOVQ || f_icode == I_MRMOVQ)
      f_valC = imem.imem_bytes[79:16];

    f_valP = f_PC + ADDR_W'(instr_len(f_icode));
  end

  // Next-PC prediction: jump/call target, stack top for ret, else fall-through.
  always_comb begin
    f_predPC = f_valP;
    if (f_icode == I_JXX || f_icode == I_CALL) f_predPC = f_valC[ADDR_W-1:0];
`ifdef FETCH_RAS_EN
    else if (f_icode == I_RET && !ras_empty) f_predPC = ras_top;
`endif
  end

  assign ras_push = !F_stall && (f_stat == STAT_AOK) && (f_icode == I_CALL);
  assign ras_pop  = !F_stall && (f_stat == STAT_AOK) && (f_icode == I_RET);

`ifdef FETCH_RAS_EN
  fetch_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (f_valP),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign unused_ras = ^{ras_top, ras_empty, ras_push, ras_pop};
`endif

endmodule

// File: tb/tb_fetch_ras_unit.sv
// Directed bench for fetch_ras_unit; RAS checks are selected by FETCH_RAS_EN.
module tb_fetch_ras_unit;
  localparam int unsigned ADDR_W = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        F_stall;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        ret_mispredict;
  logic [63:0] f_PC, f_valP, f_predPC;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC;
  logic [2:0]  f_stat;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ras_unit_if #(.ADDR_W(ADDR_W)) imem_if ();

  fetch_ras_unit #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (2),
    .RESET_PC  (64'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .F_stall        (F_stall),
    .M_icode        (M_icode),
    .M_cnd          (M_cnd),
    .M_valA         (M_valA),
    .W_icode        (W_icode),
    .W_valM         (W_valM),
    .ret_mispredict (ret_mispredict),
    .imem           (imem_if),
    .f_PC           (f_PC),
    .f_valP         (f_valP),
    .f_predPC       (f_predPC),
    .f_icode        (f_icode),
    .f_ifun         (f_ifun),
    .f_rA           (f_rA),
    .f_rB           (f_rB),
    .f_valC         (f_valC),
    .f_stat         (f_stat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One non-stalled rising edge, then settle.
  task automatic step();
    F_stall = 1'b0;
    @(posedge clk);
    #1;
    F_stall = 1'b1;
    #1;
  endtask

  // Call at PC (len 9) whose fall-through is pc+9, reached through an M redirect.
  task automatic call_at(input logic [63:0] pc);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = pc;
    imem_if.imem_bytes = {8'h00, 64'h500, 8'h80};
    #1;
    check_eq("call_valP", f_valP, pc + 64'd9);
    step();
  endtask

  initial begin
    rst_n = 1'b0; F_stall = 1'b1;
    M_icode = 4'h1; M_cnd = 1'b0; M_valA = '0;
    W_icode = 4'h1; W_valM = '0; ret_mispredict = 1'b0;
    imem_if.imem_bytes = {64'h0, 8'hF2, 8'h10};
    imem_if.imem_error = 1'b0;

    @(negedge clk); #1;
    check_eq("rst_pc", f_PC, 64'h0);
    check_eq("rst_addr", imem_if.imem_addr, 64'h0);
    rst_n = 1'b1; #1;
    check_eq("nop_icode", {60'h0, f_icode}, 64'h1);
    check_eq("nop_valP", f_valP, 64'h1);
    check_eq("nop_pred", f_predPC, 64'h1);
    check_eq("nop_stat", {61'h0, f_stat}, 64'h1);
    check_eq("nop_rA", {60'h0, f_rA}, 64'hF);
    step();
    check_eq("adv_pc", f_PC, 64'h1);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0; #1;
    check_eq("async_rst_pc", f_PC, 64'h0);
    @(negedge clk); rst_n = 1'b1; #1;

    // irmovq $0x1122334455667788,%rdx
    imem_if.imem_bytes = {64'h1122334455667788, 8'hF2, 8'h30}; #1;
    check_eq("irm_icode", {60'h0, f_icode}, 64'h3);
    check_eq("irm_rA", {60'h0, f_rA}, 64'hF);
    check_eq("irm_rB", {60'h0, f_rB}, 64'h2);
    check_eq("irm_valC", f_valC, 64'h1122334455667788);
    check_eq("irm_valP", f_valP, 64'd10);
    check_eq("irm_pred", f_predPC, 64'd10);

    // Redirect priority.
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h40;
    W_icode = 4'h9; W_valM = 64'h80; ret_mispredict = 1'b1; #1;
    check_eq("redir_w", f_PC, 64'h80);
    check_eq("redir_w_addr", imem_if.imem_addr, 64'h80);
    ret_mispredict = 1'b0; #1;
`ifdef FETCH_RAS_EN
    check_eq("redir_ret_ok", f_PC, 64'h40);
`else
    check_eq("redir_ret_always", f_PC, 64'h80);
`endif
    W_icode = 4'h1; #1;
    check_eq("redir_m", f_PC, 64'h40);
    M_cnd = 1'b1; #1;
    check_eq("jmp_taken_no_redir", f_PC, 64'h0);

    // Wrap of valP at top of address space.
    M_cnd = 1'b0; M_valA = 64'hFFFF_FFFF_FFFF_FFFE; #1;
    check_eq("wrap_valP", f_valP, 64'h8);
    M_icode = 4'h1; #1;

    // Stall holds F_predPC across three edges with a call fetched.
    imem_if.imem_bytes = {8'h00, 64'h100, 8'h80}; #1;
    check_eq("call_valC", f_valC, 64'h100);
    check_eq("call_rB", {60'h0, f_rB}, 64'hF);
    check_eq("call_valP", f_valP, 64'd9);
    check_eq("call_pred", f_predPC, 64'h100);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stall_hold", f_PC, 64'h0);
    step();
    check_eq("stall_release", f_PC, 64'h100);

    // Status codes.
    imem_if.imem_bytes = {64'h0, 8'h00, 8'h00}; #1;
    check_eq("halt_stat", {61'h0, f_stat}, 64'h2);
    check_eq("halt_valP", f_valP, 64'h101);
    imem_if.imem_bytes = {64'h0, 8'hF2, 8'h30}; imem_if.imem_error = 1'b1; #1;
    check_eq("err_stat", {61'h0, f_stat}, 64'h3);
    check_eq("err_icode", {60'h0, f_icode}, 64'h1);
    check_eq("err_ifun", {60'h0, f_ifun}, 64'h0);
    imem_if.imem_error = 1'b0;
    imem_if.imem_bytes = {64'h0, 8'h00, 8'hC0}; #1;
    check_eq("ins_stat", {61'h0, f_stat}, 64'h4);

    // Return prediction: depth-2 stack, three calls then three rets.
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    call_at(64'h07);
    call_at(64'h17);
    call_at(64'h27);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h100;
    imem_if.imem_bytes = {64'h0, 8'h00, 8'h90}; #1;
`ifdef FETCH_RAS_EN
    check_eq("ret1_pred", f_predPC, 64'h30);
    step();
    check_eq("ret2_pred", f_predPC, 64'h20);
    step();
    check_eq("ret3_pred", f_predPC, 64'h101);
    step();
    check_eq("ret4_pred", f_predPC, 64'h101);
`else
    check_eq("ret1_pred", f_predPC, 64'h101);
    step();
    check_eq("ret2_pred", f_predPC, 64'h101);
`endif
    step();
    check_eq("ret_fetch_pc", f_PC, 64'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ras_unit.md
# fetch_ras_unit

Parametrised Y86-64 fetch stage: owns the F pipeline register (predicted PC), selects the fetch PC from prediction or late-stage redirects, splits the instruction byte window into icode/ifun/rA/rB/valC, and computes valP, predicted PC and fetch status. It is the next generation of the fixed 64-bit fetch: widths are parametrised, stall is supported, and an optional return-address stack predicts `ret` targets so the pipeline need not bubble on every return. It sits between instruction memory and the D register and is driven by the pipeline control block.

## Interface
- ADDR_W, 64, PC/address width (valC, valA, valM stay 64 bits; addresses truncate to ADDR_W)
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2)
- RESET_PC, 0, F_predPC value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- F_stall  in  1  hold F_predPC and RAS
- M_icode  in  4  icode in M stage
- M_cnd  in  1  branch condition from M
- M_valA  in  64  fall-through PC of jump in M
- W_icode  in  4  icode in W stage
- W_valM  in  64  return address popped by ret in W
- ret_mispredict  in  1  W-stage ret target differed from RAS prediction (tied 0 without RAS)
- imem_addr  out  ADDR_W  byte address of fetch window (= f_PC)
- imem_bytes  in  80  10 bytes from imem_addr, byte 0 in [7:0]
- imem_error  in  1  window address out of range
- f_PC, f_valP, f_predPC  out  ADDR_W  fetch PC, next sequential PC, predicted next PC
- f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields
- f_valC  out  64  constant, little-endian
- f_stat  out  3  1=AOK 2=HLT 3=ADR 4=INS

## Operation
- PC select priority: W_icode==RET → W_valM (without RAS_EN always; with RAS_EN only when ret_mispredict); else M_icode==JXX && !M_cnd → M_valA; else F_predPC. W wins over M (older instruction).
- imem_error → icode forced NOP(1), ifun 0, stat ADR. Invalid icode (>0xB) → stat INS. icode HALT → stat HLT. Else AOK.
- Length: 1 byte for halt/nop/ret; 2 for rrmovq/OPq/pushq/popq; 9 for jXX/call (valC bytes 1..8); 10 for irmovq/rmmovq/mrmovq (rA/rB byte 1, valC bytes 2..9). No register byte → rA=rB=0xF.
- valP = f_PC + length, modulo 2^ADDR_W (wrap permitted).
- f_predPC: jXX/call → valC; ret with RAS_EN → RAS top (valP if empty); otherwise valP.
- F_predPC ← f_predPC on each non-stalled edge; reset → RESET_PC.

## Timing
- Decode path fully combinational from F_predPC, M/W inputs and imem_bytes; zero-cycle latency, one instruction per cycle.
- F_stall high: F_predPC and RAS unchanged, outputs still valid for current inputs.
- Reset mid-operation clears F_predPC and RAS pointer/count asynchronously; outputs reflect RESET_PC combinationally.

## Configuration
- FETCH_RAS_EN defined: RAS_DEPTH-entry circular stack. On non-stalled edge with stat AOK: call pushes valP; ret pops. Full push overwrites oldest, count saturates at RAS_DEPTH. Empty pop predicts valP, count stays 0. Redirects do not repair the stack.
- Undefined: no stack; ret predicts valP and relies on W_valM redirect; ret_mispredict ignored.

## Structure
- Shared package y86_pkg: icode constants (HALT…POPQ, JXX=7, CALL=8, RET=9), stat codes, instruction-length function.
- One sub-module: fetch_ras (stack storage, pointer, count, push/pop, empty flag).

## Test plan
- Reset: rst_n low → f_PC=0; after release, bytes 10 F2 → icode 1, valP=1, predPC=1, stat AOK.
- irmovq $0x1122334455667788,%rdx at PC 0 → rA=F, rB=2, valC=0x1122334455667788, valP=10.
- M_icode=7, M_cnd=0, M_valA=0x40 with W_icode=9, W_valM=0x80 → f_PC=0x80 (W priority); W idle → f_PC=0x40.
- F_stall high 3 cycles with call fetched → F_predPC and RAS count unchanged.
- RAS_EN, RAS_DEPTH=2: calls at valP 0x10,0x20,0x30 then three rets → predictions 0x30, 0x20, then the third ret's own valP (stack empty; oldest overwritten).
- imem_error=1 → stat 3, icode 1; icode 0xC → stat 4.
